// File: rtl/it_pkg.sv
// Shared ITSTATE field layout, condition codes, APSR bit positions and
// the condition/advance helpers used by pre-decode and execute.
package it_pkg;

  localparam int IT_W = 8;

  // Condition codes used by name in the decode logic
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // APSR bit positions in the {N,Z,C,V,Q} vector
  localparam int APSR_N = 4;
  localparam int APSR_Z = 3;
  localparam int APSR_C = 2;
  localparam int APSR_V = 1;

  // Evaluate a 4-bit condition code against the APSR flags.
  // Odd codes invert the even base, except 1111 which always passes.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [4:0] apsr);
    logic r;
    case (cond[3:1])
      3'b000:  r = apsr[APSR_Z];
      3'b001:  r = apsr[APSR_C];
      3'b010:  r = apsr[APSR_N];
      3'b011:  r = apsr[APSR_V];
      3'b100:  r = apsr[APSR_C] & ~apsr[APSR_Z];
      3'b101:  r = (apsr[APSR_N] == apsr[APSR_V]);
      3'b110:  r = (apsr[APSR_N] == apsr[APSR_V]) & ~apsr[APSR_Z];
      default: r = 1'b1;
    endcase
    if (cond[0] && (cond != COND_NV)) r = ~r;
    return r;
  endfunction

  // Step ITSTATE to the next slot; the last slot clears the block.
  // Only the low five bits shift so the base condition [7:5] is kept.
  function automatic logic [IT_W-1:0] it_advance(input logic [IT_W-1:0] it);
    if (it[2:0] == 3'b000) return '0;
    return {it[7:5], it[3:0], 1'b0};
  endfunction

endpackage

// File: rtl/it_cond_eval.sv
// Combinational condition evaluator: cond + APSR -> pass.
module it_cond_eval
  import it_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] apsr,
  output logic       pass
);

  assign pass = cond_pass(cond, apsr);

endmodule

// File: rtl/it_seq_dec.sv
// Thumb-2 pre-decode stage: tracks ITSTATE, evaluates IT/branch
// conditions and replaces failing or UNPREDICTABLE ops with NULL_INST.
module it_seq_dec
  import it_pkg::*;
#(
  parameter int               INST_W        = 32,
  parameter logic [INST_W-1:0] NULL_INST    = '0,
  parameter bit               ALLOW_LAST_BR = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              it_restore,
  input  logic [7:0]        it_restore_val,
  input  logic [4:0]        apsr,
  input  logic              apsr_busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] inst_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] inst_out,
  output logic              out_null,
  output logic              out_unpred,
  output logic              out_in_it,
  output logic              out_it_last,
  output logic [7:0]        itstate
);

  // Top halfword of the fetched word holds the first Thumb halfword
  logic [7:0] op_hi;
  logic       is_b_t1, is_b_t3, is_bcond, is_it;
  logic [3:0] b_cond;
  logic       b_uncond;
  logic       in_it, it_last;
  logic       it_pass, b_pass;
  logic       stall, accept;
  logic       d_null, d_unpred, d_load;

  assign op_hi    = inst_in[INST_W-1 -: 8];
  // 1101cccc with cccc=111x is UDF/SVC, not a branch
  assign is_b_t1  = (op_hi[7:4] == 4'hD) && (op_hi[3:1] != 3'b111);
  assign is_b_t3  = (op_hi[7:3] == 5'b11110) && (inst_in[INST_W-17 -: 2] == 2'b10)
                    && !inst_in[INST_W-20];
  assign is_bcond = is_b_t1 | is_b_t3;
  assign b_cond   = is_b_t1 ? op_hi[3:0] : inst_in[INST_W-7 -: 4];
  assign b_uncond = (b_cond[3:1] == COND_AL[3:1]);
  // IT with a zero mask is a hint and passes straight through
  assign is_it    = (op_hi == 8'hBF) && (inst_in[INST_W-13 -: 4] != 4'h0);

  assign in_it    = (itstate[3:0] != 4'h0);
  assign it_last  = in_it && (itstate[2:0] == 3'b000);

  it_cond_eval u_it_cond (
    .cond (itstate[7:4]),
    .apsr (apsr),
    .pass (it_pass)
  );

  it_cond_eval u_b_cond (
    .cond (b_cond),
    .apsr (apsr),
    .pass (b_pass)
  );

  // Only ops whose fate depends on flags wait for a pending flag update
  assign stall    = apsr_busy & (in_it | is_bcond);
  assign in_ready = rst_n & (~out_valid | out_ready) & ~stall & ~flush & ~it_restore;
  assign accept   = in_valid & in_ready;

  // Classify the incoming op into load-IT / UNPREDICTABLE / nullify
  always_comb begin
    d_null   = 1'b0;
    d_unpred = 1'b0;
    d_load   = 1'b0;
    if (is_it && !in_it) begin
      d_load = 1'b1;
      d_null = 1'b1;
    end else if (in_it && (is_it ||
             (is_bcond && !(ALLOW_LAST_BR && it_last && b_uncond)))) begin
      d_unpred = 1'b1;
      d_null   = 1'b1;
    end else if (in_it) begin
      d_null = ~it_pass;
    end else if (is_bcond) begin
      d_null = ~b_pass;
    end
  end

  // ITSTATE register: flush clears, restore overrides, accept loads/advances
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      itstate <= '0;
    end else if (flush) begin
      itstate <= '0;
    end else if (it_restore) begin
      itstate <= it_restore_val;
    end else if (accept) begin
      if (d_load)     itstate <= inst_in[INST_W-9 -: 8];
      else if (in_it) itstate <= it_advance(itstate);
    end
  end

  // Output register: load on accept, hold under backpressure, drop on flush
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      inst_out    <= NULL_INST;
      out_null    <= 1'b0;
      out_unpred  <= 1'b0;
      out_in_it   <= 1'b0;
      out_it_last <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      inst_out    <= d_null ? NULL_INST : inst_in;
      out_null    <= d_null;
      out_unpred  <= d_unpred;
      out_in_it   <= in_it;
      out_it_last <= it_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_it_seq_dec.sv
// Self-checking bench for it_seq_dec: directed scenarios followed by
// randomized traffic, all checked against a cycle-level reference model.
module tb_it_seq_dec;

  localparam logic [31:0] NULLI = 32'h0;
  localparam bit          ALLOW = 1'b1;
  localparam logic [4:0]  FZ    = 5'b01000;
  localparam logic [31:0] ALU   = 32'h1800_1234;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, it_restore = 1'b0;
  logic [7:0]  it_restore_val = '0;
  logic [4:0]  apsr = '0;
  logic        apsr_busy = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] inst_in = '0;
  logic        in_ready, out_valid, out_null, out_unpred, out_in_it, out_it_last;
  logic [31:0] inst_out;
  logic [7:0]  itstate;

  always #5 clk = ~clk;

  it_seq_dec #(.INST_W(32), .NULL_INST(NULLI), .ALLOW_LAST_BR(ALLOW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .it_restore(it_restore),
    .it_restore_val(it_restore_val), .apsr(apsr), .apsr_busy(apsr_busy),
    .in_valid(in_valid), .in_ready(in_ready), .inst_in(inst_in),
    .out_valid(out_valid), .out_ready(out_ready), .inst_out(inst_out),
    .out_null(out_null), .out_unpred(out_unpred), .out_in_it(out_in_it),
    .out_it_last(out_it_last), .itstate(itstate)
  );

  int n_vec = 0, n_err = 0;

  // reference model state
  logic [7:0]  m_it = '0;
  logic        m_ov = 1'b0, m_null = 1'b0, m_unpred = 1'b0, m_init = 1'b0, m_last = 1'b0;
  logic [31:0] m_inst = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ARM condition table written out per mnemonic
  function automatic bit ref_pass(input logic [3:0] c, input logic [4:0] f);
    bit n, z, cf, v;
    n = f[4]; z = f[3]; cf = f[2]; v = f[1];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  // next IT slot: mask part doubles within 5 bits, block ends after the last slot
  function automatic logic [7:0] ref_adv(input logic [7:0] s);
    if ((s % 8) == 0) return 8'h00;
    return (s & 8'hE0) | ((s * 2) & 8'h1F);
  endfunction

  function automatic logic [31:0] rnd_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0, 1:    r[31:24] = 8'hBF;
      2, 3:    r[31:28] = 4'hD;
      4:       begin r[31:27] = 5'b11110; r[15:14] = 2'b10; r[12] = 1'b0; end
      default: r[31] = 1'b0;
    endcase
    return r;
  endfunction

  // drive one cycle of inputs, predict, clock, then compare outputs
  task automatic step(input logic iv, input logic [31:0] ins, input logic ordy,
                      input logic [4:0] ap, input logic busy, input logic fl,
                      input logic rs, input logic [7:0] rv);
    bit bt1, bt3, isb, isit, init, last, rdy, acc, nul, unp;
    logic [3:0] bc;
    in_valid = iv; inst_in = ins; out_ready = ordy; apsr = ap; apsr_busy = busy;
    flush = fl; it_restore = rs; it_restore_val = rv;
    bt1  = (ins[31:28] == 4'hD) && (ins[27:24] < 4'hE);
    bt3  = (ins[31:27] == 5'b11110) && (ins[15:14] == 2'b10) && !ins[12];
    isb  = bt1 || bt3;
    bc   = bt1 ? ins[27:24] : ins[25:22];
    isit = (ins[31:24] == 8'hBF) && (ins[19:16] != 0);
    init = (m_it[3:0] != 0);
    last = init && (m_it[2:0] == 0);
    rdy  = rst_n && (!m_ov || ordy) && !(busy && (init || isb)) && !fl && !rs;
    #1;
    chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    acc = iv && rdy;
    if (!rst_n) begin
      m_it = 0; m_ov = 0; m_inst = NULLI; m_null = 0; m_unpred = 0; m_init = 0; m_last = 0;
    end else if (fl) begin
      m_ov = 0; m_it = 0;
    end else begin
      if (m_ov && ordy) m_ov = 0;
      if (rs) m_it = rv;
      else if (acc) begin
        unp = 0; nul = 0;
        if (isit && !init) begin
          nul = 1; m_it = ins[23:16];
        end else begin
          if (init && (isit || (isb && !(ALLOW && last && bc >= 4'hE)))) begin
            unp = 1; nul = 1;
          end else if (init) nul = !ref_pass(m_it[7:4], ap);
          else if (isb) nul = !ref_pass(bc, ap);
          if (init) m_it = ref_adv(m_it);
        end
        m_ov = 1; m_inst = nul ? NULLI : ins; m_null = nul; m_unpred = unp;
        m_init = init; m_last = last;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("itstate", {24'b0, itstate}, {24'b0, m_it});
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
    if (m_ov) begin
      chk("inst_out", inst_out, m_inst);
      chk("out_null", {31'b0, out_null}, {31'b0, m_null});
      chk("out_unpred", {31'b0, out_unpred}, {31'b0, m_unpred});
      chk("out_in_it", {31'b0, out_in_it}, {31'b0, m_init});
      chk("out_it_last", {31'b0, out_it_last}, {31'b0, m_last});
    end
  endtask

  initial begin
    @(negedge clk);
    // reset with valid input held high
    rst_n = 1'b0;
    step(1, ALU, 1, FZ, 0, 0, 0, 0);
    step(1, ALU, 1, FZ, 0, 0, 0, 0);
    chk("rst_inst", inst_out, NULLI);
    chk("rst_flags", {28'b0, out_null, out_unpred, out_in_it, out_it_last}, 32'h0);
    rst_n = 1'b1;

    // ITTE EQ with Z=1
    step(1, 32'hBF06_0000, 1, FZ, 0, 0, 0, 0);
    chk("t2_it0", {24'b0, itstate}, 32'h06);
    step(1, ALU, 1, FZ, 0, 0, 0, 0);
    chk("t2_it1", {24'b0, itstate}, 32'h0C);
    chk("t2_op1", {31'b0, out_null}, 32'h0);
    step(1, ALU + 1, 1, FZ, 0, 0, 0, 0);
    chk("t2_it2", {24'b0, itstate}, 32'h18);
    chk("t2_op2", {31'b0, out_null}, 32'h0);
    step(1, ALU + 2, 1, FZ, 0, 0, 0, 0);
    chk("t2_it3", {24'b0, itstate}, 32'h00);
    chk("t2_op3", {30'b0, out_null, out_it_last}, 32'h3);
    chk("t2_op3_inst", inst_out, NULLI);

    // BNE outside IT
    step(1, 32'hD112_0000, 1, FZ, 0, 0, 0, 0);
    chk("t3_fail", {31'b0, out_null}, 32'h1);
    step(1, 32'hD112_0000, 1, 5'b0, 0, 0, 0, 0);
    chk("t3_pass", {30'b0, out_null, out_in_it}, 32'h0);
    chk("t3_inst", inst_out, 32'hD112_0000);

    // IT inside IT
    step(1, 32'hBF08_0000, 1, FZ, 0, 0, 0, 0);
    chk("t4_load", {24'b0, itstate}, 32'h08);
    step(1, 32'hBF08_0000, 1, FZ, 0, 0, 0, 0);
    chk("t4_unpred", {30'b0, out_unpred, out_null}, 32'h3);
    chk("t4_clear", {24'b0, itstate}, 32'h00);

    // backpressure: output held, input not accepted
    step(0, 0, 1, FZ, 0, 0, 0, 0);
    step(1, 32'h1800_AAAA, 0, FZ, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h1800_BBB0 + i, 0, FZ, 0, 0, 0, 0);
      chk("t5_hold", inst_out, 32'h1800_AAAA);
      chk("t5_rdy", {31'b0, in_ready}, 32'h0);
    end
    step(0, 0, 1, FZ, 0, 0, 0, 0);

    // apsr_busy stalls ops inside an IT block
    step(1, 32'hBF06_0000, 1, FZ, 0, 0, 0, 0);
    step(1, ALU, 1, FZ, 1, 0, 0, 0);
    step(1, ALU, 1, FZ, 1, 0, 0, 0);
    chk("t5_stall_it", {24'b0, itstate}, 32'h06);
    chk("t5_stall_ov", {31'b0, out_valid}, 32'h0);
    step(1, ALU, 1, FZ, 0, 0, 0, 0);
    chk("t5_go", {24'b0, itstate}, 32'h0C);

    // flush mid-block, then restore into the last (NE) slot
    step(1, ALU, 1, FZ, 0, 1, 0, 0);
    chk("t6_flush", {23'b0, out_valid, itstate}, 32'h0);
    step(1, ALU, 1, FZ, 0, 0, 1, 8'h18);
    chk("t6_restore", {24'b0, itstate}, 32'h18);
    step(1, ALU, 1, FZ, 0, 0, 0, 0);
    chk("t6_ne_last", {29'b0, out_null, out_in_it, out_it_last}, 32'h7);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 8, rnd_inst(), $urandom_range(0, 9) < 7,
           5'($urandom_range(0, 31)), $urandom_range(0, 4) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0,
           8'($urandom_range(0, 255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
